// File: rtl/issue_ctrl.sv
// Single-slot in-order issue controller: holds one decoded instruction, checks it
// against a 32-entry busy scoreboard and hands it to the ALU, LSU or BRU.
module issue_ctrl #(
  parameter int unsigned CtrlW = 48
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_pc_i,
  input  logic [4:0]       in_rs1_i,
  input  logic [4:0]       in_rs2_i,
  input  logic [4:0]       in_rd_i,
  input  logic             in_rs1_used_i,
  input  logic             in_rs2_used_i,
  input  logic             in_rd_used_i,
  input  logic [1:0]       in_fu_type_i,
  input  logic [CtrlW-1:0] in_ctrl_i,
  output logic             alu_valid_o,
  input  logic             alu_ready_i,
  output logic             lsu_valid_o,
  input  logic             lsu_ready_i,
  output logic             bru_valid_o,
  input  logic             bru_ready_i,
  output logic [31:0]      out_pc_o,
  output logic [4:0]       out_rs1_o,
  output logic [4:0]       out_rs2_o,
  output logic [4:0]       out_rd_o,
  output logic             out_rd_used_o,
  output logic [CtrlW-1:0] out_ctrl_o,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             flush_i,
  output logic             illegal_o,
  output logic [15:0]      stall_cnt_o
);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StHeld  = 1'b1;

  localparam logic [1:0] FuAlu = 2'd0;
  localparam logic [1:0] FuLsu = 2'd1;
  localparam logic [1:0] FuBru = 2'd2;
  localparam logic [1:0] FuIll = 2'd3;

  logic [0:0]       state_q, state_d;
  logic [31:0]      pc_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic             rs1_used_q, rs2_used_q, rd_used_q;
  logic [1:0]       fu_q;
  logic [CtrlW-1:0] ctrl_q;
  logic [31:0]      busy_q, busy_d;
  logic             illegal_q;
  logic [15:0]      stall_q, stall_d;

  logic [31:0] wb_clr, busy_eff;
  logic        held, hazard, issue_ok, fire, drop, accept;

  always_comb begin
    wb_clr = '0;
    if (wb_valid_i) wb_clr[wb_rd_i] = 1'b1;
    // A writeback in this cycle already unblocks the waiting instruction.
    busy_eff = busy_q & ~wb_clr;
    hazard   = (rs1_used_q && busy_eff[rs1_q]) ||
               (rs2_used_q && busy_eff[rs2_q]) ||
               (rd_used_q  && busy_eff[rd_q]);
  end

  always_comb begin
    held        = (state_q == StHeld);
    issue_ok    = held && !hazard && !flush_i && !rst_i;
    alu_valid_o = issue_ok && (fu_q == FuAlu);
    lsu_valid_o = issue_ok && (fu_q == FuLsu);
    bru_valid_o = issue_ok && (fu_q == FuBru);
    fire        = (alu_valid_o && alu_ready_i) || (lsu_valid_o && lsu_ready_i) ||
                  (bru_valid_o && bru_ready_i);
    drop        = held && !flush_i && (fu_q == FuIll);
    in_ready_o  = !rst_i && (!held || fire || drop || flush_i);
    accept      = in_valid_i && in_ready_o;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = StHeld;
    end else if (held && (fire || drop || flush_i)) begin
      state_d = StEmpty;
    end

    // Issue set is applied after the writeback clear so it wins on a collision.
    busy_d = busy_eff;
    if (fire && rd_used_q) busy_d[rd_q] = 1'b1;
    busy_d[0] = 1'b0;

    stall_d = stall_q;
    if (held && !flush_i && !drop && !fire && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StEmpty;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_used_q <= 1'b0;
      rs2_used_q <= 1'b0;
      rd_used_q  <= 1'b0;
      fu_q       <= '0;
      ctrl_q     <= '0;
      busy_q     <= '0;
      illegal_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      illegal_q <= drop;
      stall_q   <= stall_d;
      if (accept) begin
        pc_q       <= in_pc_i;
        rs1_q      <= in_rs1_i;
        rs2_q      <= in_rs2_i;
        rd_q       <= in_rd_i;
        rs1_used_q <= in_rs1_used_i;
        rs2_used_q <= in_rs2_used_i;
        rd_used_q  <= in_rd_used_i;
        fu_q       <= in_fu_type_i;
        ctrl_q     <= in_ctrl_i;
      end
    end
  end

  assign out_pc_o      = pc_q;
  assign out_rs1_o     = rs1_q;
  assign out_rs2_o     = rs2_q;
  assign out_rd_o      = rd_q;
  assign out_rd_used_o = rd_used_q;
  assign out_ctrl_o    = ctrl_q;
  assign illegal_o     = illegal_q;
  assign stall_cnt_o   = stall_q;

endmodule
